// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: IFU_MISALIGN_CHK_EN (see ifu_fetch.sv).
package ifu_fetch_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned ADDR_W = 64;

   typedef logic [INST_W-1:0] inst_t;
   typedef logic [ADDR_W-1:0] inst_addr_t;

   localparam inst_addr_t PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
   localparam inst_t      ZERO_WORD        = '0;

   // One buffered fetch: instruction word plus the address it came from (96 bits).
   typedef struct packed {
      inst_t      inst;
      inst_addr_t addr;
   } fetch_entry_t;

   localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

   // Clear the byte offset so the PC always points at a whole word.
   function automatic inst_addr_t align_word(input inst_addr_t a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Synchronous instruction buffer: push/pop/flush, occupancy count and a
// zero-latency head output read straight from the registered storage.
module ifu_fetch_fifo
   import ifu_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = ENTRY_W,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_head,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Pointers wrap explicitly so non-power-of-two depths also work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage, pointers and count; flush wins over push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (i_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC ownership, credit-limited fetch requests,
// in-order response capture into a small buffer, and redirect handling
// that flushes buffered entries and drops in-flight responses.
// Optional feature macro: IFU_MISALIGN_CHK_EN -- a misaligned redirect target
// halts fetching and raises fetch_misalign_o until an aligned redirect arrives.
// Without it the target's low two bits are cleared on load.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter inst_addr_t  RESET_PC   = PC_RESET_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [ADDR_W-1:0] imem_req_addr_o,
   input  logic              imem_rsp_valid_i,
   input  logic [INST_W-1:0] imem_rsp_data_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              fetch_misalign_o
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   inst_addr_t       r_pc;
   inst_addr_t       r_rsp_pc;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_drop_cnt;
   logic             w_halted;

   logic [CNT_W-1:0] w_count;
   logic [CNT_W:0]   w_credit_used;
   logic [CNT_W-1:0] w_rsp_one;
   logic             w_req_valid;
   logic             w_req_fire;
   logic             w_rsp_drop;
   logic             w_push;
   logic             w_pop;
   logic             w_inst_valid;
   inst_addr_t       w_target;
   fetch_entry_t     w_push_entry;
   fetch_entry_t     w_head;

   // Buffered plus in-flight fetches may never exceed the buffer depth, so a
   // response always finds room. Request is held off during reset too.
   assign w_credit_used = {1'b0, w_count} + {1'b0, r_outstanding};
   assign w_req_valid   = rst_n && !jump_flag_i && !w_halted && (w_credit_used < DEPTH_C);
   assign w_req_fire    = w_req_valid && imem_req_ready_i;
   assign w_rsp_one     = CNT_W'(imem_rsp_valid_i);

   // Responses belonging to a redirected-away stream are discarded.
   assign w_rsp_drop = imem_rsp_valid_i && (r_drop_cnt != '0);
   assign w_push     = imem_rsp_valid_i && !w_rsp_drop && !jump_flag_i;

   assign w_inst_valid = (w_count != '0) && !jump_flag_i;
   assign w_pop        = w_inst_valid && inst_ready_i;

`ifdef IFU_MISALIGN_CHK_EN
   logic r_halted;

   assign w_target = jump_addr_i;

   // Misaligned redirect parks the fetcher; the next aligned redirect releases it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_halted <= 1'b0;
      else if (jump_flag_i) r_halted <= (jump_addr_i[1:0] != 2'b00);
   end

   assign w_halted         = r_halted;
   assign fetch_misalign_o = r_halted;
`else
   assign w_target         = align_word(jump_addr_i);
   assign w_halted         = 1'b0;
   assign fetch_misalign_o = 1'b0;
`endif

   // Request PC and the address tag for the next accepted response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_rsp_pc <= RESET_PC;
      end else if (jump_flag_i) begin
         r_pc     <= w_target;
         r_rsp_pc <= w_target;
      end else begin
         if (w_req_fire) r_pc <= r_pc + 64'd4;
         if (w_push)     r_rsp_pc <= r_rsp_pc + 64'd4;
      end
   end

   // In-flight tracking; a redirect marks everything still outstanding as stale,
   // and a response arriving in the redirect cycle is itself old-stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else if (jump_flag_i) begin
         r_outstanding <= r_outstanding - w_rsp_one;
         r_drop_cnt    <= r_outstanding - w_rsp_one;
      end else begin
         r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - w_rsp_one;
         if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
   end

   assign w_push_entry = '{inst: imem_rsp_data_i, addr: r_rsp_pc};

   ifu_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .i_flush (jump_flag_i),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign imem_req_valid_o = w_req_valid;
   assign imem_req_addr_o  = r_pc;
   assign inst_valid_o     = w_inst_valid;
   assign inst_o           = w_head.inst;
   assign inst_addr_o      = w_head.addr;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a 1-cycle in-order memory model that can
// be told to hold its responses. Expected streams come from bench counters.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [63:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        jump_flag_i;
   logic [63:0] jump_addr_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [63:0] inst_addr_o;
   logic        fetch_misalign_o;

   int checks = 0;
   int errors = 0;
   int pops   = 0;

   logic [63:0] mem_q[$];
   bit          mem_hold;
   bit          fire_seen;
   logic [63:0] fire_addr;
   logic [63:0] exp_addr;
   logic [63:0] exp_req_addr;

   ifu_fetch dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .jump_flag_i      (jump_flag_i),
      .jump_addr_i      (jump_addr_i),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .inst_o           (inst_o),
      .inst_addr_o      (inst_addr_o),
      .fetch_misalign_o (fetch_misalign_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] memf(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   // Mid-cycle: score accepted requests and accepted instructions.
   task automatic observe();
      @(negedge clk);
      fire_seen = 1'b0;
      if (imem_req_valid_o && imem_req_ready_i) begin
         check("req_addr", imem_req_addr_o, exp_req_addr);
         exp_req_addr = exp_req_addr + 64'd4;
         fire_seen = 1'b1;
         fire_addr = imem_req_addr_o;
      end
      if (inst_valid_o && inst_ready_i) begin
         check("inst_addr", inst_addr_o, exp_addr);
         check("inst_data", {32'd0, inst_o}, {32'd0, memf(exp_addr)});
         exp_addr = exp_addr + 64'd4;
         pops++;
      end
   endtask

   // One clock: observe, edge, then present this cycle's memory response.
   task automatic step();
      observe();
      @(posedge clk);
      #1;
      if (fire_seen) mem_q.push_back(fire_addr);
      if (!mem_hold && mem_q.size() > 0) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = memf(mem_q.pop_front());
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = '0;
      end
   endtask

   task automatic wait_valid(input int maxc);
      int n;
      n = 0;
      settle();
      while (!inst_valid_o && n < maxc) begin
         step();
         settle();
         n++;
      end
      check1("wait_valid", inst_valid_o, 1'b1);
   endtask

   // Single-cycle redirect; the decode side must see nothing in that cycle.
   task automatic redirect(input logic [63:0] tgt, input logic [63:0] start);
      jump_flag_i = 1'b1;
      jump_addr_i = tgt;
      settle();
      check1("redir_inst_valid", inst_valid_o, 1'b0);
      check1("redir_req_valid", imem_req_valid_o, 1'b0);
      exp_addr     = start;
      exp_req_addr = start;
      step();
      jump_flag_i = 1'b0;
   endtask

   initial begin
      logic [63:0] a;
      int          p0;
      rst_n            = 1'b0;
      imem_req_ready_i = 1'b1;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = '0;
      jump_flag_i      = 1'b0;
      jump_addr_i      = '0;
      inst_ready_i     = 1'b1;
      mem_hold         = 1'b0;
      exp_addr         = 64'h8000_0000;
      exp_req_addr     = 64'h8000_0000;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check1("rst_inst_valid", inst_valid_o, 1'b0);
      check("rst_inst", {32'd0, inst_o}, 64'd0);
      check("rst_inst_addr", inst_addr_o, 64'd0);
      check1("rst_req_valid", imem_req_valid_o, 1'b0);
      check1("rst_misalign", fetch_misalign_o, 1'b0);

      // Release: request cycle 0, response cycle 1, instruction cycle 2
      rst_n = 1'b1;
      settle();
      check1("c0_req_valid", imem_req_valid_o, 1'b1);
      check("c0_req_addr", imem_req_addr_o, 64'h8000_0000);
      step();
      settle();
      check1("c1_inst_valid", inst_valid_o, 1'b0);
      step();
      settle();
      check1("c2_inst_valid", inst_valid_o, 1'b1);
      check("c2_inst_addr", inst_addr_o, 64'h8000_0000);
      p0 = pops;
      repeat (12) step();
      check1("stream_rate", (pops - p0) >= 6, 1'b1);

      // Decode stall: buffer fills, requests stop, head held
      inst_ready_i = 1'b0;
      settle();
      a = inst_addr_o;
      repeat (5) step();
      settle();
      check1("stall_req_valid", imem_req_valid_o, 1'b0);
      check1("stall_inst_valid", inst_valid_o, 1'b1);
      check("stall_inst_addr", inst_addr_o, a);
      check("stall_inst", {32'd0, inst_o}, {32'd0, memf(a)});
      inst_ready_i = 1'b1;
      repeat (6) step();

      // Memory not ready: address held, PC not advanced
      imem_req_ready_i = 1'b0;
      repeat (3) step();
      settle();
      check1("mstall_req_valid", imem_req_valid_o, 1'b1);
      check("mstall_addr0", imem_req_addr_o, exp_req_addr);
      a = imem_req_addr_o;
      repeat (3) step();
      settle();
      check("mstall_addr_held", imem_req_addr_o, a);
      check1("mstall_req_valid2", imem_req_valid_o, 1'b1);
      imem_req_ready_i = 1'b1;
      repeat (4) step();

      // Redirect with two in flight, one returning in the redirect cycle
      mem_hold = 1'b1;
      repeat (4) step();
      mem_hold = 1'b0;
      step();
      check1("pre_redir_rsp", imem_rsp_valid_i, 1'b1);
      check("pre_redir_pending", 64'(mem_q.size()), 64'd1);
      redirect(64'h8000_0100, 64'h8000_0100);
      wait_valid(10);
      check("redir_first_addr", inst_addr_o, 64'h8000_0100);
      repeat (6) step();

      // Back-to-back redirects: last target wins
      redirect(64'h8000_0200, 64'h8000_0200);
      redirect(64'h8000_0300, 64'h8000_0300);
      wait_valid(10);
      check("b2b_first_addr", inst_addr_o, 64'h8000_0300);
      repeat (6) step();

`ifdef IFU_MISALIGN_CHK_EN
      redirect(64'h8000_0102, 64'h8000_0102);
      settle();
      check1("mis_flag", fetch_misalign_o, 1'b1);
      check1("mis_req_valid", imem_req_valid_o, 1'b0);
      repeat (3) step();
      settle();
      check1("mis_req_valid2", imem_req_valid_o, 1'b0);
      check1("mis_flag2", fetch_misalign_o, 1'b1);
      redirect(64'h8000_0104, 64'h8000_0104);
      settle();
      check1("mis_clear", fetch_misalign_o, 1'b0);
      wait_valid(10);
      check("mis_resume_addr", inst_addr_o, 64'h8000_0104);
`else
      redirect(64'h8000_0102, 64'h8000_0100);
      settle();
      check1("mis_flag_off", fetch_misalign_o, 1'b0);
      wait_valid(10);
      check("align_first_addr", inst_addr_o, 64'h8000_0100);
`endif
      repeat (4) step();

      // PC wraps modulo 2^64
      redirect(64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC);
      wait_valid(10);
      check("wrap_first_addr", inst_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
      p0 = pops;
      repeat (6) step();
      check1("wrap_progress", (pops - p0) >= 3, 1'b1);
      check1("wrap_exp_passed_zero", exp_addr < 64'h100, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
